owner_withdraw_ctrl: RTL and testbench

Parametrised owner-withdrawal controller for the vending machine. It is the successor to the single-step clear-to-zero withdrawal: it adds a PIN check, partial or full withdrawal amounts, coin-by-coin dispensing over a ready/valid handshake, abort, error codes and lockout after repeated bad PINs. It sits between the owner keypad/service port and the machine balance register, which it updates through a one-cycle write-back strobe.

---
 rtl/vending_pkg.sv | 21 ++
 rtl/owner_withdraw_ctrl_if.sv | 35 +++
 rtl/withdraw_lock_timer.sv | 53 +++++
 rtl/owner_withdraw_ctrl.sv | 154 +++++++++++++++
 tb/tb_owner_withdraw_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending machine owner-withdrawal path.
package vending_pkg;

    localparam int MONEY_W_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_DISPENSE = 3'd2,
        S_DONE     = 3'd3,
        S_ERROR    = 3'd4,
        S_LOCKED   = 3'd5
    } state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BAD_PIN  = 3'd1;
    localparam logic [2:0] ERR_ZERO_BAL = 3'd2;
    localparam logic [2:0] ERR_OVER_BAL = 3'd3;
    localparam logic [2:0] ERR_LOCKED   = 3'd4;

endpackage

// File: rtl/owner_withdraw_ctrl_if.sv
// Keypad/service-port and coin-hopper signals of the owner-withdrawal controller.
interface owner_withdraw_ctrl_if
    import vending_pkg::*;
#(
    parameter int MONEY_W = MONEY_W_DEF,
    parameter int PIN_W   = 4
);
    logic               req;
    logic [PIN_W-1:0]   pin;
    logic [MONEY_W-1:0] amount;
    logic [MONEY_W-1:0] machine_money;
    logic               abort;
    logic               coin_ready;
    logic               coin_out;
    logic               busy;
    logic               done;
    logic               money_we;
    logic [MONEY_W-1:0] updated_machine_money;
    logic               red_light;
    logic [2:0]         err_code;
    logic               locked;

    modport master (
        output req, pin, amount, machine_money, abort, coin_ready,
        input  coin_out, busy, done, money_we, updated_machine_money,
               red_light, err_code, locked
    );

    modport slave (
        input  req, pin, amount, machine_money, abort, coin_ready,
        output coin_out, busy, done, money_we, updated_machine_money,
               red_light, err_code, locked
    );

endinterface

// File: rtl/withdraw_lock_timer.sv
// Counts consecutive bad PINs and holds the lockout window once the limit is hit.
module withdraw_lock_timer
    import vending_pkg::*;
#(
    parameter int MAX_ATTEMPTS = 3,
    parameter int LOCK_CYCLES  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic bad_pin_i,
    input  logic good_pin_i,
    output logic lock_start_o,
    output logic locked_o,
    output logic lock_done_o
);
    localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
    localparam int TMR_W = $clog2(LOCK_CYCLES + 1);

    logic [ATT_W-1:0] att_q, att_d, att_inc;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    assign att_inc      = att_q + 1'b1;
    assign lock_start_o = bad_pin_i && (att_inc == ATT_W'(MAX_ATTEMPTS));
    assign locked_o     = (tmr_q != '0);
    assign lock_done_o  = (tmr_q == TMR_W'(1));

    always_comb begin
        att_d = att_q;
        tmr_d = tmr_q;
        if (bad_pin_i) begin
            att_d = att_inc;
        end else if (good_pin_i || lock_done_o) begin
            att_d = '0;
        end
        // Loaded on the entry edge, so locked_o is high for exactly LOCK_CYCLES cycles
        if (lock_start_o) begin
            tmr_d = TMR_W'(LOCK_CYCLES);
        end else if (locked_o) begin
            tmr_d = tmr_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            att_q <= '0;
            tmr_q <= '0;
        end else begin
            att_q <= att_d;
            tmr_q <= tmr_d;
        end
    end

endmodule

// File: rtl/owner_withdraw_ctrl.sv
// Owner withdrawal: PIN check, partial/full amount, coin-by-coin dispense, abort, lockout.
module owner_withdraw_ctrl
    import vending_pkg::*;
#(
    parameter int               MONEY_W      = MONEY_W_DEF,
    parameter int               PIN_W        = 4,
    parameter logic [PIN_W-1:0] OWNER_PIN    = 4'hA,
    parameter int               MAX_ATTEMPTS = 3,
    parameter int               LOCK_CYCLES  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    owner_withdraw_ctrl_if.slave bus
);
    state_e             state_q, state_d;
    logic [PIN_W-1:0]   pin_q, pin_d;
    logic [MONEY_W-1:0] amt_q, amt_d;
    logic [MONEY_W-1:0] bal_q, bal_d;
    logic [MONEY_W-1:0] rem_q, rem_d;
    logic [MONEY_W-1:0] upd_q, upd_d;
    logic               red_q, red_d;
    logic [2:0]         err_q, err_d;

    logic in_check, pin_bad, xfer;
    logic lock_start, lock_active, lock_done;

    assign in_check = (state_q == S_CHECK);
    assign pin_bad  = (pin_q != OWNER_PIN);
    assign xfer     = (state_q == S_DISPENSE) && bus.coin_ready;

    withdraw_lock_timer #(
        .MAX_ATTEMPTS (MAX_ATTEMPTS),
        .LOCK_CYCLES  (LOCK_CYCLES)
    ) u_lock (
        .clk          (clk),
        .rst          (rst),
        .bad_pin_i    (in_check && pin_bad),
        .good_pin_i   (in_check && !pin_bad),
        .lock_start_o (lock_start),
        .locked_o     (lock_active),
        .lock_done_o  (lock_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (pin_bad) begin
                    state_d = lock_start ? S_LOCKED : S_ERROR;
                end else if (bal_q == '0 || amt_q > bal_q) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                if (bus.abort || (xfer && rem_q == MONEY_W'(1))) state_d = S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            S_ERROR:  state_d = S_IDLE;
            S_LOCKED: begin
                if (lock_done) state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy                  = (state_q != S_IDLE);
        bus.coin_out              = xfer && !rst;
        bus.done                  = (state_q == S_DONE);
        bus.money_we              = (state_q == S_DONE);
        bus.updated_machine_money = upd_q;
        bus.red_light             = red_q;
        bus.err_code              = err_q;
        bus.locked                = lock_active;
    end

    always_comb begin
        pin_d = pin_q;
        amt_d = amt_q;
        bal_d = bal_q;
        rem_d = rem_q;
        upd_d = upd_q;
        red_d = red_q;
        err_d = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    pin_d = bus.pin;
                    amt_d = bus.amount;
                    bal_d = bus.machine_money;
                    red_d = 1'b0;
                    err_d = ERR_NONE;
                end
            end
            S_CHECK: begin
                if (pin_bad) begin
                    red_d = 1'b1;
                    err_d = lock_start ? ERR_LOCKED : ERR_BAD_PIN;
                end else if (bal_q == '0) begin
                    red_d = 1'b1;
                    err_d = ERR_ZERO_BAL;
                end else if (amt_q > bal_q) begin
                    red_d = 1'b1;
                    err_d = ERR_OVER_BAL;
                end else begin
                    rem_d = (amt_q == '0) ? bal_q : amt_q;
                end
            end
            S_DISPENSE: begin
                if (xfer) begin
                    rem_d = rem_q - 1'b1;
                    bal_d = bal_q - 1'b1;
                end
                // Result is registered on the way into DONE so it is valid with money_we
                if (state_d == S_DONE) upd_d = bal_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pin_q <= '0;
            amt_q <= '0;
            bal_q <= '0;
            rem_q <= '0;
            upd_q <= '0;
            red_q <= 1'b0;
            err_q <= ERR_NONE;
        end else begin
            pin_q <= pin_d;
            amt_q <= amt_d;
            bal_q <= bal_d;
            rem_q <= rem_d;
            upd_q <= upd_d;
            red_q <= red_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_owner_withdraw_ctrl.sv
// Self-checking bench: vector table, reset-mid-dispense sequence and random transactions vs a model.
module tb_owner_withdraw_ctrl;
    import vending_pkg::*;

    localparam logic [3:0] OWNER = 4'hA;
    localparam int MAXA  = 3;
    localparam int LOCKC = 16;

    typedef struct {
        logic [3:0] p;
        int a;
        int b;
        int mode;
        int ab;
        bit poke;
        int ec;
        int ee;
        int eu;
        int el;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int tests = 0;
    int fails = 0;
    int m_att = 0;
    int m_upd = 0;
    vec_t tbl[16];

    always #5 clk = ~clk;

    owner_withdraw_ctrl_if #(.MONEY_W(8), .PIN_W(4)) bus ();

    owner_withdraw_ctrl #(
        .MONEY_W      (8),
        .PIN_W        (4),
        .OWNER_PIN    (OWNER),
        .MAX_ATTEMPTS (MAXA),
        .LOCK_CYCLES  (LOCKC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        tests++;
        if (act !== 32'(exp)) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Withdrawal outcome from the rules alone: who gets coins, how many, and the error code.
    function automatic void model(input logic [3:0] p, input int a, input int b, input int ab,
                                  output int c, output int e, output int lk);
        int want;
        c  = 0;
        e  = 0;
        lk = 0;
        if (p != OWNER) begin
            m_att++;
            if (m_att == MAXA) begin
                e = 4;
                lk = LOCKC;
                m_att = 0;
            end else begin
                e = 1;
            end
        end else begin
            m_att = 0;
            if (b == 0) e = 2;
            else if (a > b) e = 3;
            else begin
                want = (a == 0) ? b : a;
                c = (ab > 0 && ab < want) ? ab : want;
                m_upd = b - c;
            end
        end
    endfunction

    task automatic run_txn(input logic [3:0] p, input logic [7:0] a, input logic [7:0] b,
                           input int mode, input int ab, input bit poke,
                           output int coins, output int dones, output int wes, output int lockc,
                           output int first, output int mis, output bit timeout);
        bit rdy;
        coins = 0; dones = 0; wes = 0; lockc = 0; first = -1; mis = 0; timeout = 1'b1;
        @(negedge clk);
        bus.req = 1'b1;
        bus.pin = p;
        bus.amount = a;
        bus.machine_money = b;
        bus.coin_ready = 1'b0;
        bus.abort = 1'b0;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            @(negedge clk);
            bus.req = poke && (lockc == 5);
            if (bus.req) begin
                bus.pin = OWNER;
                bus.machine_money = 8'd3;
            end
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 2 == 0);
            else rdy = ($urandom_range(99) < 60);
            bus.coin_ready = rdy;
            bus.abort = (ab > 0) && rdy && (coins + 1 == ab);
            #1;
            if (bus.coin_out && bus.coin_ready) begin
                if (first < 0) first = cyc;
                coins++;
            end
            if (bus.done) dones++;
            if (bus.money_we) wes++;
            if (bus.done !== bus.money_we) mis++;
            if (bus.locked) lockc++;
            if (!bus.busy) begin
                timeout = 1'b0;
                break;
            end
        end
        bus.req = 1'b0;
        bus.abort = 1'b0;
        bus.coin_ready = 1'b0;
    endtask

    task automatic check_txn(input string nm, input vec_t v);
        int c, d, w, l, f, mis;
        bit to;
        run_txn(v.p, 8'(v.a), 8'(v.b), v.mode, v.ab, v.poke, c, d, w, l, f, mis, to);
        chk({nm, ".timeout"}, to, 0);
        chk({nm, ".coins"}, c, v.ec);
        chk({nm, ".done_pulses"}, d, (v.ee == 0) ? 1 : 0);
        chk({nm, ".we_pulses"}, w, (v.ee == 0) ? 1 : 0);
        chk({nm, ".done_we_align"}, mis, 0);
        chk({nm, ".lock_cycles"}, l, v.el);
        if (v.mode == 0 && v.ec > 0) chk({nm, ".latency"}, f, 2);
        @(negedge clk);
        #1;
        chk({nm, ".idle_after"}, bus.busy, 0);
        chk({nm, ".red_light"}, bus.red_light, (v.ee != 0) ? 1 : 0);
        chk({nm, ".err_code"}, bus.err_code, v.ee);
        chk({nm, ".updated_money"}, bus.updated_machine_money, v.eu);
    endtask

    initial begin
        int c, e, lk, coins;
        vec_t r;

        tbl[0]  = '{4'hA, 0,   5,   0, 0,   1'b0, 5,   0, 0,   0};
        tbl[1]  = '{4'hA, 3,   10,  1, 0,   1'b0, 3,   0, 7,   0};
        tbl[2]  = '{4'hA, 0,   0,   0, 0,   1'b0, 0,   2, 7,   0};
        tbl[3]  = '{4'hA, 6,   4,   0, 0,   1'b0, 0,   3, 7,   0};
        tbl[4]  = '{4'hA, 1,   1,   0, 0,   1'b0, 1,   0, 0,   0};
        tbl[5]  = '{4'h5, 0,   9,   0, 0,   1'b0, 0,   1, 0,   0};
        tbl[6]  = '{4'h5, 0,   9,   0, 0,   1'b0, 0,   1, 0,   0};
        tbl[7]  = '{4'h5, 0,   9,   0, 0,   1'b1, 0,   4, 0,   16};
        tbl[8]  = '{4'hA, 0,   9,   0, 4,   1'b0, 4,   0, 5,   0};
        tbl[9]  = '{4'h5, 2,   3,   0, 0,   1'b0, 0,   1, 5,   0};
        tbl[10] = '{4'hA, 2,   3,   2, 0,   1'b0, 2,   0, 1,   0};
        tbl[11] = '{4'h5, 2,   3,   0, 0,   1'b0, 0,   1, 1,   0};
        tbl[12] = '{4'h5, 2,   3,   0, 0,   1'b0, 0,   1, 1,   0};
        tbl[13] = '{4'hA, 0,   255, 0, 0,   1'b0, 255, 0, 0,   0};
        tbl[14] = '{4'hA, 255, 255, 2, 100, 1'b0, 100, 0, 155, 0};
        tbl[15] = '{4'hA, 7,   7,   0, 0,   1'b0, 7,   0, 0,   0};

        rst = 1'b1;
        bus.req = 1'b0;
        bus.pin = '0;
        bus.amount = '0;
        bus.machine_money = '0;
        bus.abort = 1'b0;
        bus.coin_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.busy", bus.busy, 0);
        chk("reset.coin_out", bus.coin_out, 0);
        chk("reset.done", bus.done, 0);
        chk("reset.money_we", bus.money_we, 0);
        chk("reset.updated_money", bus.updated_machine_money, 0);
        chk("reset.red_light", bus.red_light, 0);
        chk("reset.err_code", bus.err_code, 0);
        chk("reset.locked", bus.locked, 0);

        for (int i = 0; i < 16; i++) begin
            model(tbl[i].p, tbl[i].a, tbl[i].b, tbl[i].ab, c, e, lk);
            check_txn($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset in the middle of a 6-coin withdrawal.
        coins = 0;
        @(negedge clk);
        bus.req = 1'b1;
        bus.pin = OWNER;
        bus.amount = 8'd0;
        bus.machine_money = 8'd6;
        bus.coin_ready = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            if (bus.coin_out) coins++;
        end
        chk("rstmid.coins_before", coins, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid.coin_out_in_rst", bus.coin_out, 0);
        chk("rstmid.we_in_rst", bus.money_we, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid.busy", bus.busy, 0);
        chk("rstmid.coin_out", bus.coin_out, 0);
        chk("rstmid.money_we", bus.money_we, 0);
        chk("rstmid.done", bus.done, 0);
        chk("rstmid.updated_money", bus.updated_machine_money, 0);
        chk("rstmid.red_light", bus.red_light, 0);
        chk("rstmid.err_code", bus.err_code, 0);
        bus.coin_ready = 1'b0;
        m_att = 0;
        m_upd = 0;

        for (int i = 0; i < 40; i++) begin
            r.p = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : OWNER;
            r.b = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(40, 1));
            case ($urandom_range(3))
                0:       r.a = 0;
                1:       r.a = int'($urandom_range(r.b, 0));
                2:       r.a = int'($urandom_range(60, 0));
                default: r.a = r.b;
            endcase
            r.ab   = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(45, 1));
            r.mode = 2;
            r.poke = 1'b0;
            model(r.p, r.a, r.b, r.ab, r.ec, r.ee, r.el);
            r.eu = m_upd;
            check_txn($sformatf("rnd%0d", i), r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
